// File: rtl/btn_debounce.sv
// btn_debounce: conditions a raw, bouncing push-button/switch signal into a clean
// synchronous level plus single-cycle rise/fall pulses.
//
// A two-flop synchronizer feeds a four-state qualification FSM. A new level is
// accepted only after the synchronized input has held the opposite value for
// STABLE_CYCLES consecutive samples while the FSM waits in a *_WAIT state.
//
// Ports:
//   clk    - single clock, all logic on its rising edge
//   reset  - asynchronous, active-low reset (0 = reset asserted)
//   btn_in - raw asynchronous button/switch input
//   level  - debounced, registered level
//   rise   - one-cycle pulse in the cycle level first reads 1
//   fall   - one-cycle pulse in the cycle level first reads 0
//   busy   - high while a candidate transition is being qualified

module btn_debounce #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_WIDTH = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLow      = 2'd0,
        StRiseWait = 2'd1,
        StHigh     = 2'd2,
        StFallWait = 2'd3
    } state_e;

    logic sync1_q;
    logic sync2_q;
    logic s;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            StLow: begin
                if (s) begin
                    state_d = StRiseWait;
                    cnt_d   = '0;
                end
            end
            StRiseWait: begin
                // A revert seen on the final qualifying sample still aborts.
                if (!s) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StHigh;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StHigh: begin
                if (!s) begin
                    state_d = StFallWait;
                    cnt_d   = '0;
                end
            end
            StFallWait: begin
                if (s) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StLow;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign busy  = (state_q == StRiseWait) || (state_q == StFallWait);

endmodule
